control_sequencer: RTL and testbench

- Parametrised successor to the 16-bit processor control unit.
- Accepts one decoded instruction per valid/ready handshake and latches opcode, flags and operand selects.
- Sequences the 15 one-hot control lines over one or more cycles.
- Waits on a memory acknowledge for stack/store ops and holds branches for a programmable number of cycles. This replaces delay-based branch timing.

---
 rtl/control_sequencer_pkg.sv | 72 +++++++
 rtl/control_sequencer_if.sv | 38 +++
 rtl/control_sequencer_decode.sv | 101 ++++++++++
 rtl/control_sequencer.sv | 166 ++++++++++++++++
 tb/tb_control_sequencer.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/control_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_seq_pkg
//  Description : Shared definitions for the control sequencer: control-line
//                bit indices and masks, state encoding, opcode constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_seq_pkg;

  localparam int CL_W = 15;

  // Control-line bit positions
  localparam int CL_MOVE     = 0;
  localparam int CL_STORE    = 1;
  localparam int CL_BRANCH   = 2;
  localparam int CL_POP      = 3;
  localparam int CL_PUSH     = 4;
  localparam int CL_STALL    = 5;
  localparam int CL_STR_REZ  = 6;
  localparam int CL_LOAD_Y   = 7;
  localparam int CL_LOAD_X   = 8;
  localparam int CL_ACC_OPX  = 9;
  localparam int CL_ACC_OPY  = 10;
  localparam int CL_JMP      = 11;
  localparam int CL_RET      = 12;
  localparam int CL_RESET_CU = 13;
  localparam int CL_DONE     = 14;

  // One-hot masks for building control words
  localparam logic [CL_W-1:0] CW_MOVE     = CL_W'(1) << CL_MOVE;
  localparam logic [CL_W-1:0] CW_STORE    = CL_W'(1) << CL_STORE;
  localparam logic [CL_W-1:0] CW_BRANCH   = CL_W'(1) << CL_BRANCH;
  localparam logic [CL_W-1:0] CW_POP      = CL_W'(1) << CL_POP;
  localparam logic [CL_W-1:0] CW_PUSH     = CL_W'(1) << CL_PUSH;
  localparam logic [CL_W-1:0] CW_STALL    = CL_W'(1) << CL_STALL;
  localparam logic [CL_W-1:0] CW_STR_REZ  = CL_W'(1) << CL_STR_REZ;
  localparam logic [CL_W-1:0] CW_LOAD_Y   = CL_W'(1) << CL_LOAD_Y;
  localparam logic [CL_W-1:0] CW_LOAD_X   = CL_W'(1) << CL_LOAD_X;
  localparam logic [CL_W-1:0] CW_ACC_OPX  = CL_W'(1) << CL_ACC_OPX;
  localparam logic [CL_W-1:0] CW_ACC_OPY  = CL_W'(1) << CL_ACC_OPY;
  localparam logic [CL_W-1:0] CW_JMP      = CL_W'(1) << CL_JMP;
  localparam logic [CL_W-1:0] CW_RET      = CL_W'(1) << CL_RET;
  localparam logic [CL_W-1:0] CW_RESET_CU = CL_W'(1) << CL_RESET_CU;
  localparam logic [CL_W-1:0] CW_DONE     = CL_W'(1) << CL_DONE;

  // Sequencer states (5-bit encoding is visible on the state output)
  typedef enum logic [4:0] {
    ST_IDLE     = 5'd0,
    ST_DISPATCH = 5'd1,
    ST_EXEC     = 5'd2,
    ST_MEM_WAIT = 5'd3,
    ST_BR_HOLD  = 5'd4,
    ST_HALT     = 5'd5,
    ST_ERROR    = 5'd6
  } state_t;

  // Opcode constants, zero-extended to 32 bits for width-independent compares
  localparam logic [31:0] OP_HALT    = 32'h00;
  localparam logic [31:0] OP_LOAD    = 32'h01;
  localparam logic [31:0] OP_STORE   = 32'h02;
  localparam logic [31:0] OP_BRCOND  = 32'h03;
  localparam logic [31:0] OP_NOP_LO  = 32'h06;
  localparam logic [31:0] OP_BR      = 32'h07;
  localparam logic [31:0] OP_CALL    = 32'h08;
  localparam logic [31:0] OP_RET     = 32'h09;
  localparam logic [31:0] OP_ACC     = 32'h10;
  localparam logic [31:0] OP_NOP_18  = 32'h18;
  localparam logic [31:0] OP_NOP_19  = 32'h19;
  localparam logic [31:0] OP_PUSH    = 32'h1C;

endpackage
`default_nettype wire

// File: rtl/control_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer_if
//  Description : Instruction handshake, memory handshake and status bundle
//                between an instruction source and the control sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface control_sequencer_if #(
  parameter int OPC_W  = 6,
  parameter int FLAG_W = 4
);
  logic              start;
  logic              instr_valid;
  logic              instr_ready;
  logic [OPC_W-1:0]  opcode;
  logic              reg_s;
  logic              acc_s;
  logic [FLAG_W-1:0] flags;
  logic              mem_ack;
  logic              mem_req;
  logic [14:0]       control_lines;
  logic [4:0]        state;
  logic              done;
  logic              err;

  // Instruction/memory source side
  modport master (
    output start, instr_valid, opcode, reg_s, acc_s, flags, mem_ack,
    input  instr_ready, mem_req, control_lines, state, done, err
  );

  // Sequencer side
  modport slave (
    input  start, instr_valid, opcode, reg_s, acc_s, flags, mem_ack,
    output instr_ready, mem_req, control_lines, state, done, err
  );
endinterface
`default_nettype wire

// File: rtl/control_sequencer_decode.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_seq_decode
//  Description : Combinational opcode decoder: latched opcode/selects/flags
//                to control word plus memory/branch/halt/trap classification.
//                Build option CTRL_ILLEGAL_TRAP_EN turns opcodes
//                0x1D..(all-ones - 1) into traps instead of pops.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_seq_decode
  import ctrl_seq_pkg::*;
#(
  parameter int OPC_W  = 6,
  parameter int FLAG_W = 4
) (
  input  logic [OPC_W-1:0]  i_opcode,
  input  logic              i_reg_s,
  input  logic              i_acc_s,
  input  logic [FLAG_W-1:0] i_flags,
  output logic [CL_W-1:0]   o_word,
  output logic              o_is_mem,
  output logic              o_is_branch,
  output logic              o_is_halt,
  output logic              o_is_trap
);

  localparam logic [31:0] c_ALL_ONES = 32'((64'd1 << OPC_W) - 64'd1);

  logic [31:0]     w_op;
  logic            w_cond_taken;
  logic [CL_W-1:0] w_load;

  assign w_op   = 32'(i_opcode);
  assign w_load = i_reg_s ? CW_LOAD_Y : CW_LOAD_X;

  // Conditional branch 0x03+i is taken when flag i is set
  always_comb begin
    w_cond_taken = 1'b0;
    for (int i = 0; i < FLAG_W; i++) begin
      if (w_op == OP_BRCOND + 32'(i) && i_flags[i]) w_cond_taken = 1'b1;
    end
  end

  // Opcode map
  always_comb begin
    o_word      = '0;
    o_is_mem    = 1'b0;
    o_is_branch = 1'b0;
    o_is_halt   = 1'b0;
    o_is_trap   = 1'b0;
    if (w_op == OP_HALT) begin
      o_word    = CW_DONE;
      o_is_halt = 1'b1;
    end else if (w_op == OP_LOAD) begin
      o_word = w_load;
    end else if (w_op == OP_STORE) begin
      o_word   = CW_STORE;
      o_is_mem = 1'b1;
    end else if (w_op >= OP_BRCOND && w_op <= OP_NOP_LO) begin
      // untaken or out-of-range flag index decodes as NOP
      if (w_cond_taken) begin
        o_word      = CW_BRANCH;
        o_is_branch = 1'b1;
      end
    end else if (w_op == OP_BR) begin
      o_word      = CW_BRANCH;
      o_is_branch = 1'b1;
    end else if (w_op == OP_CALL) begin
      o_word   = CW_BRANCH | CW_PUSH | CW_JMP;
      o_is_mem = 1'b1;
    end else if (w_op == OP_RET) begin
      o_word   = CW_BRANCH | CW_POP | CW_RET;
      o_is_mem = 1'b1;
    end else if (w_op == OP_ACC) begin
      case ({i_reg_s, i_acc_s})
        2'b11:   o_word = CW_ACC_OPY;
        2'b10:   o_word = CW_ACC_OPY | CW_MOVE | CW_STR_REZ;
        2'b01:   o_word = CW_ACC_OPX;
        default: o_word = CW_ACC_OPX | CW_MOVE | CW_STR_REZ;
      endcase
    end else if ((w_op >= 32'h0A && w_op <= 32'h0F) ||
                 (w_op >= 32'h11 && w_op <= 32'h17) ||
                 w_op == 32'h1A || w_op == 32'h1B) begin
      o_word = CW_STR_REZ;
    end else if (w_op == OP_PUSH) begin
      o_word   = CW_STORE | CW_PUSH;
      o_is_mem = 1'b1;
    end else if (w_op == OP_NOP_18 || w_op == OP_NOP_19 || w_op == c_ALL_ONES) begin
      o_word = '0;
    end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
      o_is_trap = 1'b1;
`else
      o_word   = CW_POP | w_load;
      o_is_mem = 1'b1;
`endif
    end
  end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer
//  Description : Multi-cycle control sequencer. Accepts one decoded
//                instruction per valid/ready handshake, sequences the one-hot
//                control lines, waits on memory acknowledge with timeout and
//                holds branches for BR_HOLD cycles. Build option
//                CTRL_ILLEGAL_TRAP_EN (in ctrl_seq_decode) traps illegal ops.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int OPC_W       = 6,
  parameter int FLAG_W      = 4,
  parameter int BR_HOLD     = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  control_sequencer_if.slave bus
);

  localparam int CNT_MAX = (MEM_TIMEOUT > BR_HOLD) ? MEM_TIMEOUT : BR_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] c_MEM_TO  = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] c_BR_HOLD = CNT_W'(BR_HOLD);
  localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next, w_cnt_inc;
  logic              w_latch;

  logic [OPC_W-1:0]  r_opcode;
  logic              r_reg_s;
  logic              r_acc_s;
  logic [FLAG_W-1:0] r_flags;

  logic [CL_W-1:0]   w_word;
  logic              w_is_mem, w_is_branch, w_is_halt, w_is_trap;

  // Decode works only on latched instruction fields
  ctrl_seq_decode #(.OPC_W(OPC_W), .FLAG_W(FLAG_W)) u_decode (
    .i_opcode    (r_opcode),
    .i_reg_s     (r_reg_s),
    .i_acc_s     (r_acc_s),
    .i_flags     (r_flags),
    .o_word      (w_word),
    .o_is_mem    (w_is_mem),
    .o_is_branch (w_is_branch),
    .o_is_halt   (w_is_halt),
    .o_is_trap   (w_is_trap)
  );

  assign w_cnt_inc = r_cnt + c_ONE;

  // State and wait-counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Instruction fields captured only on an accepted handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_opcode <= '0;
      r_reg_s  <= 1'b0;
      r_acc_s  <= 1'b0;
      r_flags  <= '0;
    end else if (w_latch) begin
      r_opcode <= bus.opcode;
      r_reg_s  <= bus.reg_s;
      r_acc_s  <= bus.acc_s;
      r_flags  <= bus.flags;
    end
  end

  // Next-state logic and Moore outputs (state + latched opcode only)
  always_comb begin
    w_next            = r_state;
    w_cnt_next        = r_cnt;
    w_latch           = 1'b0;
    bus.control_lines = '0;
    bus.instr_ready   = 1'b0;
    bus.mem_req       = 1'b0;
    bus.done          = 1'b0;
    bus.err           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.control_lines = CW_RESET_CU;
        if (bus.start) w_next = ST_DISPATCH;
      end
      ST_DISPATCH: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) begin
          w_latch = 1'b1;
          w_next  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        bus.control_lines = w_word;
        bus.mem_req       = w_is_mem;
        w_cnt_next        = '0;
        if (w_is_halt) begin
          w_next = ST_HALT;
        end else if (w_is_trap) begin
          w_next = ST_ERROR;
        end else if (w_is_mem) begin
          w_next = bus.mem_ack ? ST_DISPATCH : ST_MEM_WAIT;
        end else if (w_is_branch && BR_HOLD > 1) begin
          // EXEC is the first of the BR_HOLD branch cycles
          w_next     = ST_BR_HOLD;
          w_cnt_next = c_ONE;
        end else begin
          w_next = ST_DISPATCH;
        end
      end
      ST_MEM_WAIT: begin
        bus.control_lines = w_word | CW_STALL;
        bus.mem_req       = 1'b1;
        if (bus.mem_ack) begin
          w_next     = ST_DISPATCH;
          w_cnt_next = '0;
        end else if (w_cnt_inc == c_MEM_TO) begin
          w_next     = ST_ERROR;
          w_cnt_next = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      ST_BR_HOLD: begin
        bus.control_lines = CW_BRANCH;
        if (w_cnt_inc >= c_BR_HOLD) begin
          w_next     = ST_DISPATCH;
          w_cnt_next = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      ST_HALT: begin
        bus.control_lines = CW_DONE;
        bus.done          = 1'b1;
        w_next            = ST_IDLE;
      end
      ST_ERROR: begin
        // err is sticky simply because ERROR is left only via start
        bus.control_lines = CW_STALL;
        bus.err           = 1'b1;
        if (bus.start) w_next = ST_DISPATCH;
      end
      default: begin
        w_next     = ST_IDLE;
        w_cnt_next = '0;
      end
    endcase
  end

  assign bus.state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_sequencer
//  Description : Self-checking bench for control_sequencer: directed steps
//                followed by randomized instructions against a rule-level
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

  localparam int OPC_W       = 6;
  localparam int FLAG_W      = 4;
  localparam int BR_HOLD     = 2;
  localparam int MEM_TIMEOUT = 15;

  // Control-line masks written from the bit map
  localparam logic [14:0] B_MOVE  = 15'h0001, B_STORE = 15'h0002,
                          B_BRANCH= 15'h0004, B_POP   = 15'h0008,
                          B_PUSH  = 15'h0010, B_STALL = 15'h0020,
                          B_STRREZ= 15'h0040, B_LOADY = 15'h0080,
                          B_LOADX = 15'h0100, B_ACCX  = 15'h0200,
                          B_ACCY  = 15'h0400, B_JMP   = 15'h0800,
                          B_RET   = 15'h1000, B_RESET = 15'h2000,
                          B_DONE  = 15'h4000;

  localparam int K_PLAIN = 0, K_HALT = 1, K_MEM = 2, K_BR = 3, K_TRAP = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  control_sequencer_if #(.OPC_W(OPC_W), .FLAG_W(FLAG_W)) bus ();

  control_sequencer #(
    .OPC_W(OPC_W), .FLAG_W(FLAG_W), .BR_HOLD(BR_HOLD), .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: what each opcode does, straight from the opcode rules
  function automatic void model(input int op, input bit rs, input bit as,
                                input logic [3:0] fl,
                                output logic [14:0] w, output int kind);
    logic [14:0] ld;
    ld   = rs ? B_LOADY : B_LOADX;
    w    = '0;
    kind = K_PLAIN;
    if (op == 0) begin
      w = B_DONE; kind = K_HALT;
    end else if (op == 1) begin
      w = ld;
    end else if (op == 2) begin
      w = B_STORE; kind = K_MEM;
    end else if (op >= 3 && op <= 6) begin
      if ((op - 3) < FLAG_W && fl[op-3]) begin
        w = B_BRANCH; kind = K_BR;
      end
    end else if (op == 7) begin
      w = B_BRANCH; kind = K_BR;
    end else if (op == 8) begin
      w = B_BRANCH | B_PUSH | B_JMP; kind = K_MEM;
    end else if (op == 9) begin
      w = B_BRANCH | B_POP | B_RET; kind = K_MEM;
    end else if (op == 16) begin
      if (rs) w = as ? B_ACCY : (B_ACCY | B_MOVE | B_STRREZ);
      else    w = as ? B_ACCX : (B_ACCX | B_MOVE | B_STRREZ);
    end else if ((op >= 10 && op <= 15) || (op >= 17 && op <= 23) || op == 26 || op == 27) begin
      w = B_STRREZ;
    end else if (op == 28) begin
      w = B_STORE | B_PUSH; kind = K_MEM;
    end else if (op == 24 || op == 25 || op == (1 << OPC_W) - 1) begin
      w = '0;
    end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
      kind = K_TRAP;
`else
      w = B_POP | ld; kind = K_MEM;
`endif
    end
  endfunction

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // Issue one instruction from DISPATCH; d = cycle index (EXEC=0) of mem_ack
  task automatic run_instr(input int op, input bit rs, input bit as,
                           input logic [3:0] fl, input int d);
    logic [14:0] w;
    int kind;
    int k;
    model(op, rs, as, fl, w, kind);
    chk("dispatch_ready", 32'(bus.instr_ready), 32'd1);
    bus.instr_valid = 1'b1;
    bus.opcode      = OPC_W'(op);
    bus.reg_s       = rs;
    bus.acc_s       = as;
    bus.flags       = fl;
    bus.mem_ack     = 1'b0;
    step();
    // scramble inputs: the sequencer must use its latched copy
    bus.instr_valid = 1'b0;
    bus.opcode      = OPC_W'($urandom);
    bus.reg_s       = 1'($urandom);
    bus.acc_s       = 1'($urandom);
    bus.flags       = FLAG_W'($urandom);
    chk($sformatf("exec_lines op%0h", op), 32'(bus.control_lines), 32'(w));
    chk("exec_ready", 32'(bus.instr_ready), 32'd0);
    chk("exec_memreq", 32'(bus.mem_req), (kind == K_MEM) ? 32'd1 : 32'd0);
    case (kind)
      K_HALT: begin
        step();
        chk("halt_lines", 32'(bus.control_lines), 32'(B_DONE));
        chk("halt_done", 32'(bus.done), 32'd1);
        step();
        chk("idle_lines", 32'(bus.control_lines), 32'(B_RESET));
        chk("idle_done", 32'(bus.done), 32'd0);
        chk("idle_ready", 32'(bus.instr_ready), 32'd0);
        pulse_start();
      end
      K_MEM: begin
        k = 0;
        forever begin
          bus.mem_ack = (k == d);
          step();
          if (k == d) begin
            bus.mem_ack = 1'b0;
            chk("mem_done_ready", 32'(bus.instr_ready), 32'd1);
            chk("mem_done_req", 32'(bus.mem_req), 32'd0);
            break;
          end
          k++;
          if (k > MEM_TIMEOUT) begin
            bus.mem_ack = 1'b0;
            chk("timeout_err", 32'(bus.err), 32'd1);
            chk("timeout_lines", 32'(bus.control_lines), 32'(B_STALL));
            chk("timeout_memreq", 32'(bus.mem_req), 32'd0);
            step();
            chk("err_sticky", 32'(bus.err), 32'd1);
            pulse_start();
            chk("err_cleared", 32'(bus.err), 32'd0);
            break;
          end
          chk($sformatf("wait%0d_lines", k), 32'(bus.control_lines), 32'(w | B_STALL));
          chk("wait_memreq", 32'(bus.mem_req), 32'd1);
        end
      end
      K_BR: begin
        for (int i = 1; i < BR_HOLD; i++) begin
          step();
          chk("brhold_lines", 32'(bus.control_lines), 32'(B_BRANCH));
        end
        step();
        chk("br_done_lines", 32'(bus.control_lines), 32'd0);
      end
      K_TRAP: begin
        step();
        chk("trap_err", 32'(bus.err), 32'd1);
        chk("trap_lines", 32'(bus.control_lines), 32'(B_STALL));
        pulse_start();
      end
      default: begin
        step();
        chk("plain_done_lines", 32'(bus.control_lines), 32'd0);
      end
    endcase
    chk("back_ready", 32'(bus.instr_ready), 32'd1);
  endtask

  initial begin
    int op, d;
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.instr_valid = 1'b0;
    bus.opcode      = '0;
    bus.reg_s       = 1'b0;
    bus.acc_s       = 1'b0;
    bus.flags       = '0;
    bus.mem_ack     = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_lines", 32'(bus.control_lines), 32'(B_RESET));
    chk("rst_ready", 32'(bus.instr_ready), 32'd0);
    chk("rst_memreq", 32'(bus.mem_req), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    reset = 1'b0;
    step();
    chk("idle_wait_ready", 32'(bus.instr_ready), 32'd0);
    pulse_start();

    // Halt, conditional branch taken / not taken, call with 3-cycle ack
    run_instr(8'h00, 1'b0, 1'b0, 4'b0000, 0);
    run_instr(8'h04, 1'b0, 1'b0, 4'b0010, 0);
    run_instr(8'h04, 1'b0, 1'b0, 4'b0000, 0);
    run_instr(8'h08, 1'b0, 1'b0, 4'b0000, 3);

    // Store with no ack: timeout into ERROR, start recovers
    run_instr(8'h02, 1'b0, 1'b0, 4'b0000, 1000);

    // Accumulator op for all four select combinations
    for (int i = 0; i < 4; i++) run_instr(8'h10, i[1], i[0], 4'b0000, 0);

    // Zero-wait ack in EXEC, unconditional branch, push, ret
    run_instr(8'h02, 1'b0, 1'b0, 4'b0000, 0);
    run_instr(8'h07, 1'b0, 1'b0, 4'b0000, 0);
    run_instr(8'h1C, 1'b0, 1'b0, 4'b0000, 2);
    run_instr(8'h09, 1'b0, 1'b0, 4'b0000, 1);

    // Reset asserted mid MEM_WAIT takes effect without a clock edge
    bus.instr_valid = 1'b1;
    bus.opcode      = OPC_W'(2);
    step();
    bus.instr_valid = 1'b0;
    step();
    chk("mw_lines", 32'(bus.control_lines), 32'(B_STORE | B_STALL));
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_memreq", 32'(bus.mem_req), 32'd0);
    chk("async_rst_lines", 32'(bus.control_lines), 32'(B_RESET));
    chk("async_rst_ready", 32'(bus.instr_ready), 32'd0);
    step();
    reset = 1'b0;
    pulse_start();

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, (1 << OPC_W) - 1));
      d  = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 4));
      run_instr(op, 1'($urandom), 1'($urandom), 4'($urandom), d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
